// File: rtl/gate_tt_bist.sv
// gate_tt_bist: self-test sequencer for one 2-input combinational gate.
// It walks {a,b} through 00,01,10,11 and lets each vector settle for SETTLE cycles.
// It then samples the gate output and compares it against the EXP_TT truth table.
// It reports pass/fail, the mismatch count and the index of the first failing vector.
// Optional feature macro: GATE_TT_BIST_RESP_EN adds resp_tt, the captured response per vector.
module gate_tt_bist #(
  parameter logic [3:0]  EXP_TT = 4'b1110,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
`ifdef GATE_TT_BIST_RESP_EN
  output logic [3:0] resp_tt,
`endif
  output logic [1:0] fail_idx
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    FIN
  } state_t;

  localparam logic [3:0] SETTLE_CNT = SETTLE[3:0];

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dutA_q, dutA_d;
  logic       dutB_q, dutB_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] errCount_q, errCount_d;
  logic [1:0] failIdx_q, failIdx_d;
`ifdef GATE_TT_BIST_RESP_EN
  logic [3:0] resp_q, resp_d;
`endif

  // State and result registers; reset aborts a run immediately with no done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 4'd0;
      dutA_q     <= 1'b0;
      dutB_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errCount_q <= 3'd0;
      failIdx_q  <= 2'd0;
`ifdef GATE_TT_BIST_RESP_EN
      resp_q     <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dutA_q     <= dutA_d;
      dutB_q     <= dutB_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      errCount_q <= errCount_d;
      failIdx_q  <= failIdx_d;
`ifdef GATE_TT_BIST_RESP_EN
      resp_q     <= resp_d;
`endif
    end
  end

  // Next-state logic: vector sequencing, settle countdown, and response compare in SAMPLE only
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dutA_d     = dutA_q;
    dutB_d     = dutB_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    errCount_d = errCount_q;
    failIdx_d  = failIdx_q;
`ifdef GATE_TT_BIST_RESP_EN
    resp_d     = resp_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = DRIVE;
          idx_d      = 2'd0;
          dutA_d     = 1'b0;
          dutB_d     = 1'b0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          errCount_d = 3'd0;
          failIdx_d  = 2'd0;
`ifdef GATE_TT_BIST_RESP_EN
          resp_d     = 4'd0;
`endif
        end
      end
      DRIVE: begin
        cnt_d   = SETTLE_CNT;
        state_d = (SETTLE_CNT == 4'd0) ? SAMPLE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (dut_y !== EXP_TT[idx_q]) begin
          errCount_d = errCount_q + 3'd1;
          if (errCount_q == 3'd0) begin
            failIdx_d = idx_q;
          end
        end
`ifdef GATE_TT_BIST_RESP_EN
        resp_d[idx_q] = dut_y;
`endif
        if (idx_q == 2'd3) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 2'd1;
          dutA_d  = idx_d[1];
          dutB_d  = idx_d[0];
          state_d = DRIVE;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (errCount_q == 3'd0);
        dutA_d  = 1'b0;
        dutB_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dut_a     = dutA_q;
  assign dut_b     = dutB_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = errCount_q;
  assign fail_idx  = failIdx_q;
`ifdef GATE_TT_BIST_RESP_EN
  assign resp_tt   = resp_q;
`endif

endmodule
